seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment scanner driving DIGITS common-anode-select digits from a packed hex word. It adds several things to the fixed 4-digit scanner: configurable digit count and scan rate, per-digit decimal points, leading-zero blanking, frame-coherent input snapshots and optional per-digit blinking. It sits between the register/debug datapath and the board display pins.

---
 rtl/seg_scan_display.sv | 143 ++++++++++++++
 tb/tb_seg_scan_display.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame-coherent input snapshots and leading-zero blanking.
// Per-digit blinking is built only when SEG_DISPLAY_BLINK_EN is defined.
module seg_scan_display #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIV          = 10000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PMax   = PW'(DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8 || DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("seg_scan_display: illegal parameter value");
  end

  logic [PW-1:0]       pcnt_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tick, capture;
  logic [4*DIGITS-1:0] data_q, src_data;
  logic [DIGITS-1:0]   dp_q, src_dp;
  logic                lz_q, src_lz;
  logic                lz_hit, digit_hidden;
  logic [DIGITS-1:0]   an_d;
  logic [7:0]          seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  assign tick    = (pcnt_q == PMax);
  assign idx_d   = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
  assign capture = tick && (idx_q == IdxMax);

  // Digit 0 is encoded in the same cycle the snapshot is taken, so it reads the live inputs.
  assign src_data = capture ? data     : data_q;
  assign src_dp   = capture ? dp       : dp_q;
  assign src_lz   = capture ? lz_blank : lz_q;

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FMax = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]     fcnt_q;
  logic              phase_q, frame_phase_q, src_phase;
  logic [DIGITS-1:0] blink_q, src_blink;

  // frame_phase_q holds the phase the current frame started with, so a whole frame blinks alike.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q        <= '0;
      phase_q       <= 1'b1;
      frame_phase_q <= 1'b1;
      blink_q       <= '0;
    end else if (capture) begin
      blink_q       <= blink_mask;
      frame_phase_q <= phase_q;
      if (fcnt_q == FMax) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign src_blink    = capture ? blink_mask : blink_q;
  assign src_phase    = capture ? phase_q : frame_phase_q;
  assign digit_hidden = ~src_phase & src_blink[idx_d];
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign digit_hidden      = 1'b0;
`endif

  always_comb begin
    lz_hit = src_lz && (idx_d != '0);
    for (int j = 0; j < int'(DIGITS); j++) begin
      if (j >= int'(idx_d) && src_data[4*j +: 4] != 4'h0) lz_hit = 1'b0;
    end
    seg_d = {src_dp[idx_d], lz_hit ? 7'h00 : hex7(src_data[4*idx_d +: 4])};
    if (digit_hidden) seg_d = 8'h00;
    an_d = '0;
    for (int j = 0; j < int'(DIGITS); j++) begin
      an_d[j] = (j == int'(idx_d));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q     <= '0;
      idx_q      <= IdxMax;
      an         <= '0;
      seg        <= 8'h00;
      frame_tick <= 1'b0;
      data_q     <= '0;
      dp_q       <= '0;
      lz_q       <= 1'b0;
    end else begin
      frame_tick <= capture;
      pcnt_q     <= tick ? '0 : pcnt_q + 1'b1;
      if (tick) begin
        idx_q <= idx_d;
        an    <= an_d;
        seg   <= seg_d;
      end
      if (capture) begin
        data_q <= data;
        dp_q   <= dp;
        lz_q   <= lz_blank;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display: a slot/frame arithmetic model predicts an, seg and
// frame_tick every cycle from the inputs the bench itself drives.
module tb_seg_scan_display;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned DIV          = 4;
  localparam int unsigned BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  seg_scan_display #(
    .DIGITS       (DIGITS),
    .DIV          (DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          edge_n;
  logic [15:0] s_data;
  logic [3:0]  s_dp;
  logic        s_lz;
  logic [3:0]  s_bm;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_ft;
  logic [6:0]  hex_tab [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    edge_n  = 0;
    s_data  = '0;
    s_dp    = '0;
    s_lz    = 1'b0;
    s_bm    = '0;
    exp_an  = '0;
    exp_seg = 8'h00;
    exp_ft  = 1'b0;
  endtask

  // One clock: advance the model by slot arithmetic, then compare all outputs.
  task automatic step();
    int         k;
    int         d;
    logic [3:0] nib;
    logic [6:0] g;
    @(posedge clk);
    edge_n++;
    exp_ft = 1'b0;
    if (edge_n % DIV == 0) begin
      k = edge_n / DIV - 1;
      d = k % DIGITS;
      if (d == 0) begin
        s_data = data;
        s_dp   = dp;
        s_lz   = lz_blank;
        s_bm   = blink_mask;
        exp_ft = 1'b1;
      end
      nib = 4'(s_data >> (4 * d));
      g   = hex_tab[nib];
      if (s_lz && d > 0 && (s_data >> (4 * d)) == 16'h0) g = 7'h00;
      exp_seg = {s_dp[d], g};
`ifdef SEG_DISPLAY_BLINK_EN
      if (((k / DIGITS) / BLINK_FRAMES) % 2 == 1 && s_bm[d]) exp_seg = 8'h00;
`endif
      exp_an = 4'b0001 << d;
    end
    #1;
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("frame_tick", 32'(frame_tick), 32'(exp_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int nz;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    // Reset state and first frames with 12AF
    data = 16'h12AF;
    repeat (3) @(negedge clk);
    check_eq("reset_an", 32'(an), 32'h0);
    check_eq("reset_seg", 32'(seg), 32'h0);
    check_eq("reset_ft", 32'(frame_tick), 32'h0);
    reset = 1'b1;
    model_reset();
    run(40);

    // Leading-zero blanking with a decimal point on a blanked digit
    data = 16'h0050; lz_blank = 1'b1; dp = 4'b0100;
    run(36);
    data = 16'h0000; dp = 4'b0000;
    run(32);

    // Mid-frame change: align to digit 2 of a frame, then change data
    lz_blank = 1'b0; data = 16'h1111;
    while (!(edge_n % (DIV * DIGITS) == DIV * 3 - 1)) step();
    run(16);
    data = 16'h2222;
    run(34);

    // Blink mask on digit 0 over several frames
    data = 16'h8888; blink_mask = 4'b0001;
    run(DIV * DIGITS * 8);

    // Reset pulsed low mid-slot
    run(2);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_an", 32'(an), 32'h0);
    check_eq("midrst_seg", 32'(seg), 32'h0);
    check_eq("midrst_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(40);

    // Randomized inputs changed at random times
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        nz         = $urandom_range(0, 4);
        data       = 16'($urandom & ((32'h1 << (4 * nz)) - 1));
        dp         = 4'($urandom);
        lz_blank   = 1'($urandom);
        blink_mask = 4'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
